// File: rtl/calc_pkg.sv
// Shared control-word encodings for the calculator datapath and its control unit.
package calc_pkg;

  // MUX1 write-data select
  localparam logic [1:0] S1_ALU  = 2'b00;
  localparam logic [1:0] S1_ZERO = 2'b01;
  localparam logic [1:0] S1_IN2  = 2'b10;
  localparam logic [1:0] S1_IN1  = 2'b11;

  // ALU opcodes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // MUX2 output-register load
  localparam logic S2_LOAD = 1'b1;

  // Register-file addresses
  localparam logic [1:0] REG_R0 = 2'b00;
  localparam logic [1:0] REG_R1 = 2'b01;
  localparam logic [1:0] REG_R2 = 2'b10;
  localparam logic [1:0] REG_R3 = 2'b11;

endpackage

// File: rtl/calc_regfile.sv
// 4 x WIDTH register file: one write port, two enabled registered read ports, R0 hardwired
// to zero.
module calc_regfile
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [1:0]       i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic             i_rea,
  input  logic [1:0]       i_raa,
  input  logic             i_reb,
  input  logic [1:0]       i_rab,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  logic [WIDTH-1:0] r_r1, r_r2, r_r3;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] w_rd_a, w_rd_b;

  always_comb begin
    w_rd_a = '0;
    unique case (i_raa)
      REG_R0: w_rd_a = '0;
      REG_R1: w_rd_a = r_r1;
      REG_R2: w_rd_a = r_r2;
      REG_R3: w_rd_a = r_r3;
      default: w_rd_a = '0;
    endcase
  end

  always_comb begin
    w_rd_b = '0;
    unique case (i_rab)
      REG_R0: w_rd_b = '0;
      REG_R1: w_rd_b = r_r1;
      REG_R2: w_rd_b = r_r2;
      REG_R3: w_rd_b = r_r3;
      default: w_rd_b = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else if (i_we) begin
      unique case (i_wa)
        REG_R0: ;  // writes to R0 are discarded
        REG_R1: r_r1 <= i_wd;
        REG_R2: r_r2 <= i_wd;
        REG_R3: r_r3 <= i_wd;
        default: ;
      endcase
    end
  end

  // Reads sample the pre-edge array, so a same-cycle write is seen one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_rea) r_a <= w_rd_a;
      if (i_reb) r_b <= w_rd_b;
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: operand muxing, register file, ALU and display register.
// Optional ovf/zero flag ports are built when CALC_FLAGS_EN is defined.
module calc_datapath
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic [1:0]       i_s1,
  input  logic [1:0]       i_wa,
  input  logic             i_we,
  input  logic [1:0]       i_raa,
  input  logic             i_rea,
  input  logic [1:0]       i_rab,
  input  logic             i_reb,
  input  logic [1:0]       i_c,
  input  logic             i_s2,
  input  logic             i_done,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_valid
`ifdef CALC_FLAGS_EN
  ,
  output logic             o_ovf,
  output logic             o_zero
`endif
);

  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  calc_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_we   (i_we),
    .i_wa   (i_wa),
    .i_wd   (w_wd),
    .i_rea  (i_rea),
    .i_raa  (i_raa),
    .i_reb  (i_reb),
    .i_rab  (i_rab),
    .o_a    (w_a),
    .o_b    (w_b)
  );

`ifdef CALC_FLAGS_EN
  logic w_carry;
  assign {w_carry, w_add} = {1'b0, w_a} + {1'b0, w_b};
`else
  assign w_add = w_a + w_b;
`endif

  always_comb begin
    w_alu = '0;
    unique case (i_c)
      ALU_ADD: w_alu = w_add;
      ALU_SUB: w_alu = w_a - w_b;
      ALU_AND: w_alu = w_a & w_b;
      ALU_XOR: w_alu = w_a ^ w_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_wd = '0;
    unique case (i_s1)
      S1_ALU:  w_wd = w_alu;
      S1_ZERO: w_wd = '0;
      S1_IN2:  w_wd = i_in2;
      S1_IN1:  w_wd = i_in1;
      default: w_wd = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (i_s2 == S2_LOAD) r_out <= w_a;
      // done takes priority over the clear caused by a new write
      if (i_done)    r_out_valid <= 1'b1;
      else if (i_we) r_out_valid <= 1'b0;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;

`ifdef CALC_FLAGS_EN
  logic r_ovf, r_zero;
  logic w_flag_upd;
  logic w_ovf_nxt;

  assign w_flag_upd = i_we && (i_s1 == S1_ALU) && (i_wa != REG_R0);

  always_comb begin
    w_ovf_nxt = 1'b0;
    unique case (i_c)
      ALU_ADD: w_ovf_nxt = w_carry;
      ALU_SUB: w_ovf_nxt = (w_a < w_b);
      default: w_ovf_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_flag_upd) begin
      r_ovf  <= w_ovf_nxt;
      r_zero <= (w_alu == '0);
    end
  end

  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;
`endif

endmodule
